// File: rtl/beta_clk_gen.sv
// Programmable clock-enable generator for the Beta board: run/step/halt modes,
// boundary-synchronised config loads. Define CLKGEN_PERIOD_CNT_EN to build period_count.
module beta_clk_gen #(
  parameter int unsigned      CNT_W      = 32,
  parameter logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(30000000),
  parameter logic [CNT_W-1:0] DEF_HIGH   = CNT_W'(2000000)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             step,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_div,
  output logic             tick,
  output logic             wrap,
  output logic             busy,
  output logic [31:0]      period_count
);

  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic [CNT_W-1:0] high_reg, high_next;
  logic             step_pending_reg, step_pending_next;
  logic             pend_valid_reg, pend_valid_next;
  logic [CNT_W-1:0] pend_period_reg, pend_period_next;
  logic [CNT_W-1:0] pend_high_reg, pend_high_next;
  logic             cfg_err_reg, cfg_err_next;
  logic             clk_div_reg, clk_div_next;
  logic             tick_reg, tick_next;
  logic             wrap_reg, wrap_next;

  logic             accept;
  logic             cfg_ok;
  logic             at_wrap;
  logic             run_next;
  logic [CNT_W-1:0] low_len_next;

  // Once a write is parked for the next boundary, further writes must wait.
  assign cfg_ready = (state_reg == IDLE) || !pend_valid_reg;
  assign accept    = cfg_valid && cfg_ready;
  assign cfg_ok    = (cfg_period >= CNT_W'(2)) && (cfg_high != '0) && (cfg_high < cfg_period);
  assign at_wrap   = (state_reg == RUN) && (count_reg == period_reg - CNT_W'(1));

  always_comb begin
    state_next        = state_reg;
    count_next        = count_reg;
    period_next       = period_reg;
    high_next         = high_reg;
    step_pending_next = step_pending_reg;
    pend_valid_next   = pend_valid_reg;
    pend_period_next  = pend_period_reg;
    pend_high_next    = pend_high_reg;
    cfg_err_next      = accept && !cfg_ok;

    case (state_reg)
      IDLE: begin
        count_next = '0;
        if (accept && cfg_ok) begin
          period_next = cfg_period;
          high_next   = cfg_high;
        end
        if (mode == MODE_RUN || (mode == MODE_STEP && (step || step_pending_reg))) begin
          state_next        = RUN;
          step_pending_next = 1'b0;
        end else if (mode != MODE_STEP) begin
          step_pending_next = 1'b0;
        end
      end

      RUN: begin
        if (accept && cfg_ok) begin
          pend_valid_next  = 1'b1;
          pend_period_next = cfg_period;
          pend_high_next   = cfg_high;
        end
        if (mode != MODE_STEP) begin
          step_pending_next = 1'b0;
        end else if (step) begin
          step_pending_next = 1'b1;
        end

        if (at_wrap) begin
          count_next      = '0;
          pend_valid_next = 1'b0;
          // A write landing in the wrap cycle bypasses the holding slot.
          if (pend_valid_reg) begin
            period_next = pend_period_reg;
            high_next   = pend_high_reg;
          end else if (accept && cfg_ok) begin
            period_next = cfg_period;
            high_next   = cfg_high;
          end

          if (mode == MODE_RUN) begin
            state_next = RUN;
          end else if (mode == MODE_STEP && (step_pending_reg || step)) begin
            state_next        = RUN;
            step_pending_next = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          count_next = count_reg + CNT_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  // Strobes are computed from next-state values so the registered copies line up with count.
  always_comb begin
    run_next     = (state_next == RUN);
    low_len_next = period_next - high_next;
    clk_div_next = run_next && (count_next >= low_len_next);
    tick_next    = run_next && (count_next == low_len_next);
    wrap_next    = run_next && (count_next == period_next - CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      count_reg        <= '0;
      period_reg       <= DEF_PERIOD;
      high_reg         <= DEF_HIGH;
      step_pending_reg <= 1'b0;
      pend_valid_reg   <= 1'b0;
      pend_period_reg  <= '0;
      pend_high_reg    <= '0;
      cfg_err_reg      <= 1'b0;
      clk_div_reg      <= 1'b0;
      tick_reg         <= 1'b0;
      wrap_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      count_reg        <= count_next;
      period_reg       <= period_next;
      high_reg         <= high_next;
      step_pending_reg <= step_pending_next;
      pend_valid_reg   <= pend_valid_next;
      pend_period_reg  <= pend_period_next;
      pend_high_reg    <= pend_high_next;
      cfg_err_reg      <= cfg_err_next;
      clk_div_reg      <= clk_div_next;
      tick_reg         <= tick_next;
      wrap_reg         <= wrap_next;
    end
  end

  assign cfg_err = cfg_err_reg;
  assign clk_div = clk_div_reg;
  assign tick    = tick_reg;
  assign wrap    = wrap_reg;
  assign busy    = (state_reg == RUN);

`ifdef CLKGEN_PERIOD_CNT_EN
  logic [31:0] period_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      period_count_reg <= 32'd0;
    end else if (at_wrap) begin
      period_count_reg <= period_count_reg + 32'd1;
    end
  end

  assign period_count = period_count_reg;
`else
  assign period_count = 32'd0;
`endif

endmodule

// File: tb/tb_beta_clk_gen.sv
// Testbench for beta_clk_gen: directed scenarios then random traffic, checked every
// cycle against a period-position model (CNT_W=8, DEF_PERIOD=10, DEF_HIGH=3).
module tb_beta_clk_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        step;
  logic        cfg_valid;
  logic [7:0]  cfg_period;
  logic [7:0]  cfg_high;
  logic        cfg_ready;
  logic        cfg_err;
  logic        clk_div;
  logic        tick;
  logic        wrap;
  logic        busy;
  logic [31:0] period_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: running flag, position in period, active/parked settings.
  bit          m_run;
  int          m_pos;
  int          m_p, m_h;
  bit          m_park;
  int          m_park_p, m_park_h;
  bit          m_step_owed;
  bit          m_err;
  int unsigned m_wraps;

  beta_clk_gen #(.CNT_W(8), .DEF_PERIOD(8'd10), .DEF_HIGH(8'd3)) dut (
    .clk(clk), .rst(rst), .mode(mode), .step(step), .cfg_valid(cfg_valid),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_ready(cfg_ready),
    .cfg_err(cfg_err), .clk_div(clk_div), .tick(tick), .wrap(wrap),
    .busy(busy), .period_count(period_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_p = 10; m_h = 3;
    m_park = 0; m_park_p = 0; m_park_h = 0;
    m_step_owed = 0; m_err = 0; m_wraps = 0;
  endtask

  task automatic model_step(input bit r, input int md, input bit st, input bit cv,
                            input int cp, input int ch);
    bit ready, acc, ok, last;
    ready = !m_run || !m_park;
    acc   = cv && ready;
    ok    = (cp >= 2) && (ch >= 1) && (ch <= cp - 1);
    if (r) begin
      model_reset();
      return;
    end
    m_err = acc && !ok;
    if (!m_run) begin
      if (acc && ok) begin m_p = cp; m_h = ch; end
      if (md == 1 || (md == 2 && (st || m_step_owed))) begin
        m_run = 1; m_pos = 0; m_step_owed = 0;
      end else if (md != 2) begin
        m_step_owed = 0;
      end
    end else begin
      last = (m_pos == m_p - 1);
      if (last) begin
        m_wraps++;
        if (m_park) begin m_p = m_park_p; m_h = m_park_h; end
        else if (acc && ok) begin m_p = cp; m_h = ch; end
        m_park = 0;
        m_pos  = 0;
        if (md == 1) m_run = 1;
        else if (md == 2 && (m_step_owed || st)) m_step_owed = 0;
        else m_run = 0;
        if (md != 2) m_step_owed = 0;
      end else begin
        if (acc && ok) begin m_park = 1; m_park_p = cp; m_park_h = ch; end
        m_pos++;
        if (md != 2) m_step_owed = 0;
        else if (st) m_step_owed = 1;
      end
    end
  endtask

  task automatic check_all();
    int unsigned exp_pc;
`ifdef CLKGEN_PERIOD_CNT_EN
    exp_pc = m_wraps;
`else
    exp_pc = 0;
`endif
    chk("clk_div",   {31'd0, clk_div},   {31'd0, m_run && (m_pos >= m_p - m_h)});
    chk("tick",      {31'd0, tick},      {31'd0, m_run && (m_pos == m_p - m_h)});
    chk("wrap",      {31'd0, wrap},      {31'd0, m_run && (m_pos == m_p - 1)});
    chk("busy",      {31'd0, busy},      {31'd0, m_run});
    chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, !m_run || !m_park});
    chk("cfg_err",   {31'd0, cfg_err},   {31'd0, m_err});
    chk("period_count", period_count, exp_pc);
  endtask

  task automatic do_cycle(input bit r, input int md, input bit st, input bit cv,
                          input int cp, input int ch);
    @(negedge clk);
    rst = r; mode = 2'(md); step = st; cfg_valid = cv;
    cfg_period = 8'(cp); cfg_high = 8'(ch);
    model_step(r, md, st, cv, cp, ch);
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic idle_cycles(input int md, input int n);
    for (int i = 0; i < n; i++) do_cycle(0, md, 0, 0, 0, 0);
  endtask

  initial begin
    int md;
    int guard;
    int unsigned exp3;
    rst = 1; mode = 0; step = 0; cfg_valid = 0; cfg_period = 0; cfg_high = 0;
    model_reset();

    // Reset state
    do_cycle(1, 0, 0, 0, 0, 0);
    do_cycle(1, 0, 0, 0, 0, 0);

    // Free-run for three periods, then halt
    idle_cycles(1, 31);
    idle_cycles(0, 12);

    // Single step, then three steps inside one period
    do_cycle(0, 2, 1, 0, 0, 0);
    idle_cycles(2, 14);
    do_cycle(0, 2, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) do_cycle(0, 2, (i % 2 == 1), 0, 0, 0);
    idle_cycles(2, 25);

    // Reconfigure to P=4, H=1 at count 2 of a running period
    do_cycle(0, 1, 0, 0, 0, 0);
    idle_cycles(1, 2);
    do_cycle(0, 1, 0, 1, 4, 1);
    idle_cycles(1, 20);
    idle_cycles(0, 6);

    // Restore defaults, then invalid writes leave settings unchanged
    do_cycle(0, 0, 0, 1, 10, 3);
    do_cycle(0, 0, 0, 1, 5, 0);
    idle_cycles(0, 1);
    do_cycle(0, 0, 0, 1, 5, 5);
    idle_cycles(0, 1);
    do_cycle(0, 0, 0, 1, 1, 1);
    idle_cycles(0, 1);
    idle_cycles(1, 22);

    // Write accepted in the wrap cycle applies to the next period
    guard = 0;
    while (!(m_run && m_pos == m_p - 1) && guard < 40) begin
      idle_cycles(1, 1); guard++;
    end
    do_cycle(0, 1, 0, 1, 6, 2);
    idle_cycles(1, 13);

    // Reset at count 8 while a config is parked
    do_cycle(0, 0, 0, 1, 10, 3);
    guard = 0;
    while (m_run && guard < 40) begin idle_cycles(0, 1); guard++; end
    do_cycle(0, 1, 0, 1, 10, 3);
    idle_cycles(1, 2);
    do_cycle(0, 1, 0, 1, 6, 2);
    guard = 0;
    while (m_pos != 8 && guard < 40) begin idle_cycles(1, 1); guard++; end
    do_cycle(1, 1, 0, 0, 0, 0);
    chk("rst_clk_div", {31'd0, clk_div}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Exactly three periods since reset
    do_cycle(0, 1, 0, 0, 0, 0);
    idle_cycles(1, 30);
`ifdef CLKGEN_PERIOD_CNT_EN
    exp3 = 3;
`else
    exp3 = 0;
`endif
    chk("period_count_3", period_count, exp3);
    idle_cycles(0, 12);

    // Random traffic
    md = 1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: md = 1;
          5, 6, 7:       md = 2;
          8:             md = 0;
          default:       md = 3;
        endcase
      end
      do_cycle($urandom_range(0, 199) == 0, md, $urandom_range(0, 5) == 0,
               $urandom_range(0, 7) == 0, int'($urandom_range(0, 9)),
               int'($urandom_range(0, 9)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/beta_clk_gen.md
# beta_clk_gen

Programmable processor clock-enable generator for the Beta processor board, replacing fixed-constant dividers. It produces a divided clock `clk_div` with a runtime-loadable period and high-window, plus single-cycle `tick` and `wrap` strobes. It supports free-run, single-step and halt modes so the processor can be clocked continuously or stepped one period per button press. Configuration writes use a valid/ready handshake and take effect only at period boundaries, so no partial period is ever produced.

## Interface
- `CNT_W`, 32: width of the counter and config fields.
- `DEF_PERIOD`, 30000000: period in `clk` cycles after reset.
- `DEF_HIGH`, 2000000: `clk_div` high-window length after reset.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `mode`  in  2  00 halt, 01 run, 10 step, 11 treated as halt.
- `step`  in  1  step request pulse; already debounced/one-shot upstream.
- `cfg_valid`  in  1  config write request.
- `cfg_period`  in  CNT_W  requested period.
- `cfg_high`  in  CNT_W  requested high-window.
- `cfg_ready`  out  1  config write can be accepted.
- `cfg_err`  out  1  one-cycle pulse: accepted write was invalid and discarded.
- `clk_div`  out  1  divided clock.
- `tick`  out  1  one-cycle pulse on the first high cycle of `clk_div`.
- `wrap`  out  1  one-cycle pulse on the last cycle of a period.
- `busy`  out  1  a period is in progress (state RUN).
- `period_count`  out  32  completed periods; see Configuration.

## Operation
- Active registers `P`, `H`. Constraints: `P >= 2` and `1 <= H <= P-1`. Unsigned CNT_W arithmetic; `P-H` is computed in CNT_W bits and never underflows under these constraints.
- States:
  - IDLE: `count = 0`, `clk_div = 0`.
  - RUN: `count` steps 0..P-1, so a period is exactly P cycles.
- IDLE -> RUN when `mode == 01`, or when `mode == 10` and (`step` or `step_pending`). On entry `count = 0`, and `step_pending` is cleared.
- In RUN at `count == P-1`: `wrap = 1` and `count` wraps to 0. The state then:
  - stays RUN if `mode == 01`;
  - stays RUN if `mode == 10` and `step_pending` (consumed, cleared);
  - otherwise goes to IDLE.
- Mode is evaluated only in IDLE and at wrap. A mode change mid-period never truncates the period.
- `step_pending`:
  - Set by `step` while in RUN. Holds at most one request; further pulses coalesce.
  - Cleared on consumption or whenever `mode != 10`.
  - `step` in IDLE with `mode != 10` is ignored.
- `clk_div = 1` exactly in RUN cycles with `count >= P-H`, giving H high cycles at the end of each period.
- `tick` is asserted in the cycle with `count == P-H`.
- `busy = 1` in every RUN cycle.
- Config handshake:
  - A transfer occurs on `cfg_valid && cfg_ready`.
  - In IDLE, `cfg_ready = 1`, and accepted values are active from the next cycle.
  - In RUN, the accepted values are held pending and `cfg_ready = 0` until the wrap edge. The pending values then load, and the next period uses them.
  - An invalid write is accepted, discarded, and pulses `cfg_err` in the following cycle.
- Simultaneous events:
  - A write accepted in the wrap cycle applies to the immediately following period.
  - `step` in the wrap cycle counts as pending, so one further period runs.

## Timing
- Reset values: `count = 0`, state IDLE, `P = DEF_PERIOD`, `H = DEF_HIGH`, `step_pending = 0`, pending config empty.
- Reset output values: `clk_div = 0`, `tick = 0`, `wrap = 0`, `busy = 0`, `cfg_err = 0`, `cfg_ready = 1`, `period_count = 0`.
- `rst` mid-period: on the next edge all of the above are restored, and any pending config is dropped.
- Latency:
  - IDLE -> first RUN cycle is 1 cycle after the triggering `mode`/`step` sample.
  - `clk_div`, `tick` and `wrap` are registered and aligned to `count` as specified, with no extra pipeline delay.
- `cfg_err` follows the accepting cycle by exactly 1 cycle.

## Configuration
- `CLKGEN_PERIOD_CNT_EN` defined: `period_count` increments by 1 on every wrap edge and wraps modulo 2^32.
- `CLKGEN_PERIOD_CNT_EN` undefined: `period_count` is tied to 0 and no counter logic is built.

## Test plan
All scenarios use `DEF_PERIOD = 10`, `DEF_HIGH = 3`, `CNT_W = 8`.
- Run mode after reset: `clk_div` is high at counts 7-9 of each 10-cycle period. `tick` fires at count 7 and `wrap` at count 9, repeating every 10 cycles.
- Step mode, one `step` pulse: exactly 10 RUN cycles with one `tick` and one `wrap`, then IDLE. Three `step` pulses within one period: exactly one additional period, then IDLE.
- Write P=4, H=1 at count 2 of a run period: `cfg_ready = 0` until the wrap. The old 10-cycle period completes, then 4-cycle periods follow with `clk_div` high only at count 3.
- Writes (P=5,H=0), (P=5,H=5) and (P=1,H=1), each accepted: `cfg_err` pulses one cycle after each write, and P=10, H=3 are unchanged.
- `rst` at count 8 (`clk_div` high) with a pending config: the next cycle has `clk_div = 0`, `busy = 0`, P=10, H=3, and the pending config is discarded.
- With the macro defined, run 3 full periods: `period_count = 3`. Without the macro, `period_count` stays 0.
